// File: rtl/cic_comb_decimator_if.sv
// Sample stream between the integrator chain and the comb/decimator stage.
interface cic_comb_decimator_if #(
  parameter int IW = 10,
  parameter int OW = 10
);
  logic          i_ce;
  logic [IW-1:0] i_data;
  logic [OW-1:0] o_data;
  logic          o_ready;

  modport master (output i_ce, output i_data, input o_data, input o_ready);
  modport slave  (input i_ce, input i_data, output o_data, output o_ready);
endinterface

// File: rtl/cic_comb_decimator.sv
// Comb half of a CIC decimator: keep every R-th sample, then N comb stages (delay M).
// Optional CIC_COMB_ROUND_EN: round-half-up with positive saturation on the output.
module cic_comb_decimator #(
  parameter int IW = 10,
  parameter int OW = 10,
  parameter int N  = 3,
  parameter int M  = 1,
  parameter int R  = 8
) (
  input logic              i_clk,
  input logic              i_reset_n,
  cic_comb_decimator_if.slave bus
);
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  logic                         ce_q, ce_d;
  logic [IW-1:0]                in_q, in_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [N:0][IW-1:0]           comb_q, comb_d;
  logic [N-1:0][M-1:0][IW-1:0]  dly_q, dly_d;
  logic [N:0]                   v_q, v_d;
  logic [OW-1:0]                out_q, out_d;
  logic                         rdy_q, rdy_d;
  logic [OW-1:0]                out_val;

`ifdef CIC_COMB_ROUND_EN
  generate
    if (IW > OW) begin : g_round
      localparam logic [IW-1:0] HALF = IW'(1) << (IW - OW - 1);
      localparam logic [OW-1:0] SAT  = {1'b0, {(OW-1){1'b1}}};
      logic [IW-1:0] rnd_sum;
      // Only a positive overflow is possible when adding a positive half-LSB.
      always_comb begin
        rnd_sum = comb_q[N] + HALF;
        out_val = (!comb_q[N][IW-1] && rnd_sum[IW-1]) ? SAT : rnd_sum[IW-1 -: OW];
      end
    end else begin : g_trunc
      always_comb out_val = comb_q[N][IW-1 -: OW];
    end
  endgenerate
`else
  always_comb out_val = comb_q[N][IW-1 -: OW];
`endif

  always_comb begin
    ce_d   = bus.i_ce;
    in_d   = bus.i_data;
    cnt_d  = cnt_q;
    comb_d = comb_q;
    dly_d  = dly_q;
    v_d    = '0;
    out_d  = out_q;
    rdy_d  = v_q[N];

    if (ce_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        comb_d[0] = in_q;
        v_d[0]    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    for (int unsigned k = 1; k <= N; k++) begin
      if (v_q[k-1]) begin
        comb_d[k]      = comb_q[k-1] - dly_q[k-1][M-1];
        dly_d[k-1][0]  = comb_q[k-1];
        for (int unsigned j = 1; j < M; j++) begin
          dly_d[k-1][j] = dly_q[k-1][j-1];
        end
        v_d[k] = 1'b1;
      end
    end

    if (v_q[N]) out_d = out_val;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ce_q   <= 1'b0;
      in_q   <= '0;
      cnt_q  <= '0;
      comb_q <= '0;
      dly_q  <= '0;
      v_q    <= '0;
      out_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      ce_q   <= ce_d;
      in_q   <= in_d;
      cnt_q  <= cnt_d;
      comb_q <= comb_d;
      dly_q  <= dly_d;
      v_q    <= v_d;
      out_q  <= out_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.o_data  = out_q;
  assign bus.o_ready = rdy_q;
endmodule

// File: tb/tb_cic_comb_decimator.sv
// Bench for cic_comb_decimator: four configurations against a transfer-function model.
module tb_cic_comb_decimator;
  localparam int ND = 4;
`ifdef CIC_COMB_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  int iw  [ND] = '{10, 10, 12, 12};
  int ow  [ND] = '{10, 10,  8,  8};
  int nst [ND] = '{ 3,  1,  1,  3};
  int md  [ND] = '{ 1,  1,  1,  2};
  int rr  [ND] = '{ 8,  1,  1,  3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ce  [ND];
  logic [11:0] din [ND];

  cic_comb_decimator_if #(.IW(10), .OW(10)) if_a ();
  cic_comb_decimator_if #(.IW(10), .OW(10)) if_b ();
  cic_comb_decimator_if #(.IW(12), .OW(8))  if_c ();
  cic_comb_decimator_if #(.IW(12), .OW(8))  if_d ();

  cic_comb_decimator #(.IW(10), .OW(10), .N(3), .M(1), .R(8)) u_a (.i_clk(clk), .i_reset_n(rst_n), .bus(if_a));
  cic_comb_decimator #(.IW(10), .OW(10), .N(1), .M(1), .R(1)) u_b (.i_clk(clk), .i_reset_n(rst_n), .bus(if_b));
  cic_comb_decimator #(.IW(12), .OW(8),  .N(1), .M(1), .R(1)) u_c (.i_clk(clk), .i_reset_n(rst_n), .bus(if_c));
  cic_comb_decimator #(.IW(12), .OW(8),  .N(3), .M(2), .R(3)) u_d (.i_clk(clk), .i_reset_n(rst_n), .bus(if_d));

  assign if_a.i_ce = ce[0];  assign if_a.i_data = din[0][9:0];
  assign if_b.i_ce = ce[1];  assign if_b.i_data = din[1][9:0];
  assign if_c.i_ce = ce[2];  assign if_c.i_data = din[2];
  assign if_d.i_ce = ce[3];  assign if_d.i_data = din[3];

  logic              act_r [ND];
  logic signed [31:0] act_d [ND];
  always_comb begin
    act_r[0] = if_a.o_ready;  act_d[0] = 32'($signed(if_a.o_data));
    act_r[1] = if_b.o_ready;  act_d[1] = 32'($signed(if_b.o_data));
    act_r[2] = if_c.o_ready;  act_d[2] = 32'($signed(if_c.o_data));
    act_r[3] = if_d.o_ready;  act_d[3] = 32'($signed(if_d.o_data));
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: kept-sample history since reset and an output schedule by cycle.
  int   acc   [ND];
  int   nk    [ND];
  int   kept  [ND][4096];
  logic due_v [ND][64];
  int   due_x [ND][64];
  logic exp_r [ND];
  int   exp_d [ND];
  int   nl    [ND];
  int   log_c [ND][8192];
  int   log_v [ND][8192];

  function automatic int sx(int d);
    int v;
    v = int'(din[d]) & ((1 << iw[d]) - 1);
    if (v >= (1 << (iw[d] - 1))) v -= (1 << iw[d]);
    return v;
  endfunction

  // y[j] = sum_i (-1)^i C(N,i) x[j-iM], reduced mod 2^IW, then truncated/rounded to OW.
  function automatic int model_out(int d, int j);
    longint y, p, s;
    int binom, sh;
    y = 0;
    binom = 1;
    for (int i = 0; i <= nst[d]; i++) begin
      if (j - i * md[d] >= 0)
        y += ((i % 2) != 0 ? -1 : 1) * longint'(binom) * longint'(kept[d][j - i * md[d]]);
      binom = binom * (nst[d] - i) / (i + 1);
    end
    p = longint'(1) << iw[d];
    y = ((y % p) + p) % p;
    if (y >= p / 2) y -= p;
    sh = iw[d] - ow[d];
    if (RND && sh > 0) begin
      s = y + (longint'(1) << (sh - 1));
      if (s > p / 2 - 1) return (1 << (ow[d] - 1)) - 1;
      return int'(s >>> sh);
    end
    return int'(y >>> sh);
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        acc[d] = 0; nk[d] = 0; exp_r[d] = 1'b0; exp_d[d] = 0;
        for (int s = 0; s < 64; s++) due_v[d][s] = 1'b0;
      end else begin
        exp_r[d] = due_v[d][cyc % 64];
        if (exp_r[d]) begin
          exp_d[d] = due_x[d][cyc % 64];
          due_v[d][cyc % 64] = 1'b0;
        end
        if (ce[d] && nk[d] < 4096) begin
          acc[d]++;
          if (acc[d] % rr[d] == 0) begin
            kept[d][nk[d]] = sx(d);
            due_x[d][(cyc + nst[d] + 2) % 64] = model_out(d, nk[d]);
            due_v[d][(cyc + nst[d] + 2) % 64] = 1'b1;
            nk[d]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int d = 0; d < ND; d++) begin
        n_cmp++;
        if (act_r[d] !== exp_r[d] || act_d[d] !== exp_d[d]) begin
          n_bad++;
          $display("FAIL out%0d cyc=%0d: got ready=%b data=%0d, want ready=%b data=%0d",
                   d, cyc, act_r[d], act_d[d], exp_r[d], exp_d[d]);
        end
        if (act_r[d] === 1'b1 && nl[d] < 8192) begin
          log_c[d][nl[d]] = cyc;
          log_v[d][nl[d]] = int'(act_d[d]);
          nl[d]++;
        end
      end
    end
  end

  function automatic int log_idx(int d, int t, int k);
    int n;
    n = 0;
    for (int i = 0; i < nl[d]; i++) begin
      if (log_c[d][i] > t) begin
        if (n == k) return i;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic int lv(int d, int t, int k);
    int i;
    i = log_idx(d, t, k);
    return (i < 0) ? -99999 : log_v[d][i];
  endfunction

  function automatic int lc(int d, int t, int k);
    int i;
    i = log_idx(d, t, k);
    return (i < 0) ? -99999 : log_c[d][i];
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      ce[d] = 1'b0; din[d] = '0;
    end
  endtask

  task automatic rand_d();
    ce[3]  = ($urandom % 3) != 0;
    din[3] = 12'($urandom);
  endtask

  int t0;
  int dens [ND];
  int c_tbl [4] = '{0, 24, 0, 2047};

  initial begin
    rst_n = 1'b0;
    idle_all();
    for (int d = 0; d < ND; d++) nl[d] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed: constant 5 on A, wrap on B, trunc/round/saturate on C.
    t0 = cyc;
    for (int i = 0; i < 60; i++) begin
      ce[0] = (i < 48); din[0] = 12'd5;
      ce[1] = (i < 2);  din[1] = (i == 0) ? 12'(500) : 12'(-500);
      ce[2] = (i < 4);  din[2] = (i < 4) ? 12'(c_tbl[i]) : '0;
      rand_d();
      @(negedge clk);
    end
    chk("a_first_cycle", lc(0, t0, 0), t0 + 13);
    chk("a_out0", lv(0, t0, 0), 5);
    chk("a_out1", lv(0, t0, 1), -10);
    chk("a_out2", lv(0, t0, 2), 5);
    chk("a_out3", lv(0, t0, 3), 0);
    chk("a_out4", lv(0, t0, 4), 0);
    chk("a_period", lc(0, t0, 3) - lc(0, t0, 2), 8);
    chk("b_out0", lv(1, t0, 0), 500);
    chk("b_out1_wrap", lv(1, t0, 1), 24);
    chk("c_out1_trunc_round", lv(2, t0, 1), RND ? 2 : 1);
    chk("c_out2_neg", lv(2, t0, 2), RND ? -1 : -2);
    chk("c_out3_sat", lv(2, t0, 3), 127);

    // Directed: i_ce every other cycle.
    rst_n = 1'b0; idle_all(); @(negedge clk); rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 150; i++) begin
      ce[0] = (i % 2 == 0) && (i < 130); din[0] = 12'd5;
      rand_d();
      @(negedge clk);
    end
    chk("gap_out0", lv(0, t0, 0), 5);
    chk("gap_out1", lv(0, t0, 1), -10);
    chk("gap_out2", lv(0, t0, 2), 5);
    chk("gap_out3", lv(0, t0, 3), 0);
    chk("gap_period", lc(0, t0, 2) - lc(0, t0, 1), 16);

    // Directed: reset after 5 samples drops them; first output after 8 new samples.
    rst_n = 1'b0; idle_all(); @(negedge clk); rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      rst_n = (i != 5);
      ce[0] = 1'b1; din[0] = 12'd5;
      rand_d();
      @(negedge clk);
    end
    rst_n = 1'b1;
    chk("rst_first_cycle", lc(0, t0, 0), t0 + 19);
    chk("rst_first_val", lv(0, t0, 0), 5);

    // Random traffic with occasional resets.
    idle_all();
    for (int blk = 0; blk < 20; blk++) begin
      for (int d = 0; d < ND; d++) dens[d] = $urandom_range(1, 4);
      for (int i = 0; i < 100; i++) begin
        rst_n = ($urandom % 250) != 0;
        for (int d = 0; d < ND; d++) begin
          ce[d]  = ($urandom % dens[d]) == 0;
          din[d] = 12'($urandom);
        end
        @(negedge clk);
      end
    end
    rst_n = 1'b1;
    idle_all();
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
